// File: rtl/xaddr_periph_ctrl_pkg.sv
// Shared address map, bus widths and read-source decode for the external peripheral bus.
// DISPLAY0..DISPLAY0+MAX_DISP-1 is reserved as one contiguous block of display channels.
package xaddr_periph_ctrl_pkg;

   localparam int unsigned EXT_ADDR_W = 8;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned MAX_DISP   = 8;

   localparam logic [EXT_ADDR_W-1:0] LED_BASE     = 8'h00;
   localparam logic [EXT_ADDR_W-1:0] SWITCH_BASE  = 8'h01;
   localparam logic [EXT_ADDR_W-1:0] BUTTON_BASE  = 8'h02;
   localparam logic [EXT_ADDR_W-1:0] BTN_RAW_BASE = 8'h03;
   localparam logic [EXT_ADDR_W-1:0] TIMER_BASE   = 8'h04;
   localparam logic [EXT_ADDR_W-1:0] LFSR_BASE    = 8'h05;
   localparam logic [EXT_ADDR_W-1:0] STATUS_BASE  = 8'h06;
   localparam logic [EXT_ADDR_W-1:0] DISPLAY0     = 8'h10;

   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_SWITCH,
      SRC_BUTTON,
      SRC_BTN_RAW,
      SRC_TIMER,
      SRC_LFSR,
      SRC_STATUS
   } rd_src_t;

   function automatic rd_src_t rd_decode(input logic [EXT_ADDR_W-1:0] a);
      rd_src_t src;
      case (a)
         SWITCH_BASE:  src = SRC_SWITCH;
         BUTTON_BASE:  src = SRC_BUTTON;
         BTN_RAW_BASE: src = SRC_BTN_RAW;
         TIMER_BASE:   src = SRC_TIMER;
         LFSR_BASE:    src = SRC_LFSR;
         STATUS_BASE:  src = SRC_STATUS;
         default:      src = SRC_NONE;
      endcase
      return src;
   endfunction

endpackage

// File: rtl/xaddr_periph_ctrl_sync.sv
// xsync_edge: two-flop synchroniser for asynchronous inputs, plus a rising-edge
// pulse derived from the synchronised value.
module xsync_edge #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic [W-1:0] rise
);

   logic [W-1:0] s1;
   logic [W-1:0] prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1   <= '0;
         q    <= '0;
         prev <= '0;
      end else begin
         s1   <= d;
         q    <= s1;
         prev <= q;
      end
   end

   assign rise = q & ~prev;

endmodule

// File: rtl/xaddr_periph_ctrl.sv
// External-bus address decoder for board I/O: combinational write strobes,
// registered read mux, sticky clear-on-read button flags and a sticky bus error flag.
module xaddr_periph_ctrl
   import xaddr_periph_ctrl_pkg::*;
#(
   parameter int unsigned SW_W   = 7,
   parameter int unsigned BTN_W  = 4,
   parameter int unsigned LFSR_W = 3,
   parameter int unsigned N_DISP = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [EXT_ADDR_W-1:0] addr,
   input  logic                  rd_en,
   input  logic                  wr_en,
   input  logic [SW_W-1:0]       switch_in,
   input  logic [BTN_W-1:0]      button_in,
   input  logic [LFSR_W-1:0]     lfsr_in,
   input  logic                  timer_in,
   output logic [DATA_W-1:0]     data_out,
   output logic                  rd_valid,
   output logic                  led_sel,
   output logic [N_DISP-1:0]     display_sel,
   output logic                  timer_sel,
   output logic                  bus_err
);

   logic [SW_W-1:0]  sw_s;
   logic [SW_W-1:0]  sw_rise_unused;
   logic [BTN_W-1:0] btn_s;
   logic [BTN_W-1:0] btn_rise;
   logic [BTN_W-1:0] btn_flags;

   xsync_edge #(.W(SW_W)) u_sw_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (switch_in),
      .q     (sw_s),
      .rise  (sw_rise_unused)
   );

   xsync_edge #(.W(BTN_W)) u_btn_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (button_in),
      .q     (btn_s),
      .rise  (btn_rise)
   );

   logic              rd_ok;
   logic              wr_ok;
   logic              conflict;
   logic              status_wr;
   logic              wr_mapped;
   logic              btn_clear;
   logic              err_now;
   rd_src_t           rd_src;
   logic [DATA_W-1:0] rd_data;

   // Simultaneous rd_en/wr_en is treated as a bus error with neither access taking effect.
   always_comb begin
      conflict    = rd_en & wr_en;
      rd_ok       = rd_en & ~wr_en;
      wr_ok       = wr_en & ~rd_en;
      rd_src      = rd_decode(addr);

      led_sel     = wr_ok && (addr == LED_BASE);
      timer_sel   = wr_ok && (addr == TIMER_BASE);
      status_wr   = wr_ok && (addr == STATUS_BASE);
      display_sel = '0;
      for (int unsigned i = 0; i < N_DISP; i++) begin
         display_sel[i] = wr_ok && (addr == DISPLAY0 + EXT_ADDR_W'(i));
      end
      wr_mapped   = led_sel | timer_sel | status_wr | (|display_sel);

      btn_clear   = rd_ok && (rd_src == SRC_BUTTON);
      err_now     = conflict | (rd_ok && (rd_src == SRC_NONE)) | (wr_ok & ~wr_mapped);

      rd_data = '0;
      case (rd_src)
         SRC_SWITCH:  rd_data = DATA_W'(sw_s);
         SRC_BUTTON:  rd_data = DATA_W'(btn_flags);
         SRC_BTN_RAW: rd_data = DATA_W'(btn_s);
         SRC_TIMER:   rd_data = DATA_W'(timer_in);
         SRC_LFSR:    rd_data = DATA_W'(lfsr_in);
         SRC_STATUS:  rd_data = DATA_W'(bus_err);
         default:     rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_out  <= '0;
         rd_valid  <= 1'b0;
         bus_err   <= 1'b0;
         btn_flags <= '0;
      end else begin
         rd_valid <= rd_ok;
         if (rd_ok) begin
            data_out <= rd_data;
         end
         // A rising edge landing on the clearing read survives the clear.
         btn_flags <= (btn_flags & ~{BTN_W{btn_clear}}) | btn_rise;
         if (err_now) begin
            bus_err <= 1'b1;
         end else if (status_wr) begin
            bus_err <= 1'b0;
         end
      end
   end

endmodule
